wordle_board_vga: RTL and testbench

WORDLE_BOARD_VGA -- requirements
Module: wordle_board_vga

---
 rtl/wordle_board_vga.sv | 272 +++++++++++++++++++++++++++
 tb/tb_wordle_board_vga.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wordle_board_vga.sv
// Wordle board renderer: 2-stage pixel pipeline drawing pegs, feedback fills and a row cursor,
// plus a per-slot animated reveal. Define WORDLE_CURSOR_BLINK_EN to make the cursor blink.
module wordle_board_vga #(
  parameter int ROWS          = 6,
  parameter int COLS          = 5,
  parameter int SYM_W         = 3,
  parameter int SLOT_W        = 48,
  parameter int SLOT_H        = 48,
  parameter int MARGIN        = 16,
  parameter int X0            = 160,
  parameter int Y0            = 50,
  parameter int RADIUS        = 16,
  parameter int REVEAL_FRAMES = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bright,
  input  logic [9:0]                 hCount,
  input  logic [9:0]                 vCount,
  input  logic [ROWS*COLS*SYM_W-1:0] matrix_flat,
  input  logic [ROWS*COLS*2-1:0]     feedback_flat,
  input  logic [$clog2(ROWS)-1:0]    guess_num,
  input  logic                       q_Input,
  input  logic                       reveal_start,
  output logic                       reveal_busy,
  output logic [3:0]                 vgaR,
  output logic [3:0]                 vgaG,
  output logic [3:0]                 vgaB
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int GN_CW   = ROW_W + 1;
  localparam int COL_W   = $clog2(COLS + 1);
  localparam int N_SLOTS = ROWS * COLS;
  localparam int IDX_W   = $clog2(N_SLOTS);
  localparam int FRM_W   = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
  localparam int PITCH_X = SLOT_W + MARGIN;
  localparam int PITCH_Y = SLOT_H + MARGIN;

  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(REVEAL_FRAMES - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  typedef enum logic {IDLE, REVEAL} state_t;

  state_t             state_reg, state_next;
  logic [ROW_W-1:0]   rev_row_reg, rev_row_next;
  logic [COL_W-1:0]   rev_col_reg, rev_col_next;
  logic [FRM_W-1:0]   rev_frm_reg, rev_frm_next;

  logic frame_tick;
  logic gn_valid;
  logic cursor_vis;

  assign frame_tick = (hCount == 10'd0) && (vCount == 10'd0);
  assign gn_valid   = GN_CW'(guess_num) < GN_CW'(ROWS);

  // Slot decode by range compare per column/row, so non-power-of-two pitches need no divider.
  logic [COLS-1:0] col_hit;
  logic [9:0]      col_dx [COLS];
  logic [ROWS-1:0] row_hit;
  logic [9:0]      row_dy [ROWS];

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      assign col_hit[gi] = (hCount >= 10'(X0 + gi * PITCH_X)) &&
                           (hCount <  10'(X0 + gi * PITCH_X + SLOT_W));
      assign col_dx[gi]  = hCount - 10'(X0 + gi * PITCH_X);
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_hit[gi] = (vCount >= 10'(Y0 + gi * PITCH_Y)) &&
                           (vCount <  10'(Y0 + gi * PITCH_Y + SLOT_H));
      assign row_dy[gi]  = vCount - 10'(Y0 + gi * PITCH_Y);
    end
  endgenerate

  logic             x_in, y_in;
  logic [COL_W-1:0] col_sel;
  logic [ROW_W-1:0] row_sel;
  logic [9:0]       dx_sel, dy_sel;

  always_comb begin
    x_in    = 1'b0;
    col_sel = '0;
    dx_sel  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_hit[c]) begin
        x_in    = 1'b1;
        col_sel = COL_W'(c);
        dx_sel  = col_dx[c];
      end
    end
    y_in    = 1'b0;
    row_sel = '0;
    dy_sel  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_hit[r]) begin
        y_in    = 1'b1;
        row_sel = ROW_W'(r);
        dy_sel  = row_dy[r];
      end
    end
  end

  logic             bright_p1_reg;
  logic             slot_p1_reg;
  logic [ROW_W-1:0] row_p1_reg;
  logic [COL_W-1:0] col_p1_reg;
  logic [9:0]       dx_p1_reg, dy_p1_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      bright_p1_reg <= 1'b0;
      slot_p1_reg   <= 1'b0;
      row_p1_reg    <= '0;
      col_p1_reg    <= '0;
      dx_p1_reg     <= '0;
      dy_p1_reg     <= '0;
    end else begin
      bright_p1_reg <= bright;
      slot_p1_reg   <= x_in && y_in;
      row_p1_reg    <= row_sel;
      col_p1_reg    <= col_sel;
      dx_p1_reg     <= dx_sel;
      dy_p1_reg     <= dy_sel;
    end
  end

  logic [SYM_W-1:0] sym_arr [N_SLOTS];
  logic [1:0]       fb_arr  [N_SLOTS];

  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      assign sym_arr[gi] = matrix_flat[gi*SYM_W +: SYM_W];
      assign fb_arr[gi]  = feedback_flat[gi*2 +: 2];
    end
  endgenerate

  logic [IDX_W-1:0]   slot_idx;
  logic [SYM_W-1:0]   sym;
  logic [1:0]         fb;
  logic signed [23:0] ddx, ddy, sq_x, sq_y;
  logic [23:0]        dist2;
  logic               in_peg, border, cursor_on, fb_shown;

  assign slot_idx = IDX_W'(row_p1_reg) * IDX_W'(COLS) + IDX_W'(col_p1_reg);
  assign sym      = sym_arr[slot_idx];
  assign fb       = fb_arr[slot_idx];

  assign ddx    = $signed({14'd0, dx_p1_reg}) - 24'(SLOT_W / 2);
  assign ddy    = $signed({14'd0, dy_p1_reg}) - 24'(SLOT_H / 2);
  assign sq_x   = ddx * ddx;
  assign sq_y   = ddy * ddy;
  assign dist2  = sq_x + sq_y;
  assign in_peg = dist2 <= 24'(RADIUS * RADIUS);

  assign border = (dx_p1_reg < 10'd2) || (dx_p1_reg >= 10'(SLOT_W - 2)) ||
                  (dy_p1_reg < 10'd2) || (dy_p1_reg >= 10'(SLOT_H - 2));

  assign cursor_on = q_Input && gn_valid && (row_p1_reg == guess_num) && border && cursor_vis;

  // Slots of the row being revealed stay unfilled until the sweep has passed them.
  assign fb_shown = !((state_reg == REVEAL) && (row_p1_reg == rev_row_reg) &&
                      (col_p1_reg >= rev_col_reg));

  logic [11:0] rgb_next, rgb_reg;

  always_comb begin
    rgb_next = 12'h000;
    if (bright_p1_reg && slot_p1_reg) begin
      if (in_peg) begin
        case (sym)
          SYM_W'(1): rgb_next = 12'h00F;
          SYM_W'(2): rgb_next = 12'h0F0;
          SYM_W'(3): rgb_next = 12'h0FF;
          SYM_W'(4): rgb_next = 12'hF00;
          SYM_W'(5): rgb_next = 12'hFF0;
          SYM_W'(6): rgb_next = 12'hF0F;
          default:   rgb_next = 12'h888;
        endcase
      end else if (cursor_on) begin
        rgb_next = 12'hFFF;
      end else if (fb_shown) begin
        case (fb)
          2'd1:    rgb_next = 12'h444;
          2'd2:    rgb_next = 12'hAA0;
          2'd3:    rgb_next = 12'h0A0;
          default: rgb_next = 12'h000;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_reg <= 12'h000;
    end else begin
      rgb_reg <= rgb_next;
    end
  end

  assign vgaR = rgb_reg[11:8];
  assign vgaG = rgb_reg[7:4];
  assign vgaB = rgb_reg[3:0];

`ifdef WORDLE_CURSOR_BLINK_EN
  logic [4:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_reg <= 5'd0;
    end else if (frame_tick) begin
      frame_cnt_reg <= frame_cnt_reg + 5'd1;
    end
  end

  assign cursor_vis = frame_cnt_reg[4];
`else
  assign cursor_vis = 1'b1;
`endif

  // A start coinciding with a tick only launches the reveal; that tick is not counted.
  always_comb begin
    state_next   = state_reg;
    rev_row_next = rev_row_reg;
    rev_col_next = rev_col_reg;
    rev_frm_next = rev_frm_reg;
    case (state_reg)
      IDLE: begin
        if (reveal_start && gn_valid) begin
          state_next   = REVEAL;
          rev_row_next = guess_num;
          rev_col_next = '0;
          rev_frm_next = '0;
        end
      end
      REVEAL: begin
        if (frame_tick) begin
          if (rev_frm_reg == FRM_LAST) begin
            rev_frm_next = '0;
            if (rev_col_reg == COL_LAST) begin
              state_next   = IDLE;
              rev_col_next = '0;
            end else begin
              rev_col_next = rev_col_reg + COL_W'(1);
            end
          end else begin
            rev_frm_next = rev_frm_reg + FRM_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      rev_row_reg <= '0;
      rev_col_reg <= '0;
      rev_frm_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rev_row_reg <= rev_row_next;
      rev_col_reg <= rev_col_next;
      rev_frm_reg <= rev_frm_next;
    end
  end

  assign reveal_busy = (state_reg == REVEAL);

endmodule

// File: tb/tb_wordle_board_vga.sv
// Bench for wordle_board_vga: per-cycle comparison against a pixel/reveal model plus
// directed probes with hand-computed colours and busy timing.
module tb_wordle_board_vga;

  localparam int ROWS = 6, COLS = 5, SYM_W = 3;
  localparam int SLOT_W = 48, SLOT_H = 48, MARGIN = 16, X0 = 160, Y0 = 50, RADIUS = 16;
  localparam int RF = 15;
  localparam int PX = SLOT_W + MARGIN;
  localparam int PY = SLOT_H + MARGIN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset, bright, q_Input, reveal_start;
  logic [9:0]                 hCount, vCount;
  logic [ROWS*COLS*SYM_W-1:0] matrix_flat;
  logic [ROWS*COLS*2-1:0]     feedback_flat;
  logic [2:0]                 guess_num;
  logic                       reveal_busy;
  logic [3:0]                 vgaR, vgaG, vgaB;

  int total = 0;
  int bad = 0;

  wordle_board_vga #(
    .ROWS(ROWS), .COLS(COLS), .SYM_W(SYM_W), .SLOT_W(SLOT_W), .SLOT_H(SLOT_H),
    .MARGIN(MARGIN), .X0(X0), .Y0(Y0), .RADIUS(RADIUS), .REVEAL_FRAMES(RF)
  ) dut (
    .clk(clk), .reset(reset), .bright(bright), .hCount(hCount), .vCount(vCount),
    .matrix_flat(matrix_flat), .feedback_flat(feedback_flat), .guess_num(guess_num),
    .q_Input(q_Input), .reveal_start(reveal_start), .reveal_busy(reveal_busy),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
  );

  // Model state: reveal progress is a tick count, hidden slots follow from it directly.
  bit          m_valid = 0;
  bit          m_rev = 0;
  int          m_rev_row = 0;
  int          m_ticks = 0;
  int          m_frames = 0;
  int          p_x = 0, p_y = 0;
  bit          p_b = 0;
  logic [11:0] m_rgb = 12'h000;

  function automatic bit cursor_phase();
`ifdef WORDLE_CURSOR_BLINK_EN
    return m_frames >= 16;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y, bit b);
    int c, r, dx, dy, d2, sym, fb;
    bit border, shown;
    if (!b || x < X0 || y < Y0) return 12'h000;
    c  = (x - X0) / PX;
    dx = (x - X0) % PX;
    r  = (y - Y0) / PY;
    dy = (y - Y0) % PY;
    if (c >= COLS || r >= ROWS || dx >= SLOT_W || dy >= SLOT_H) return 12'h000;
    sym = int'(matrix_flat[(r*COLS+c)*SYM_W +: SYM_W]);
    fb  = int'(feedback_flat[(r*COLS+c)*2 +: 2]);
    d2  = (dx - SLOT_W/2) * (dx - SLOT_W/2) + (dy - SLOT_H/2) * (dy - SLOT_H/2);
    if (d2 <= RADIUS * RADIUS) begin
      case (sym)
        1: return 12'h00F;
        2: return 12'h0F0;
        3: return 12'h0FF;
        4: return 12'hF00;
        5: return 12'hFF0;
        6: return 12'hF0F;
        default: return 12'h888;
      endcase
    end
    border = (dx < 2) || (dx >= SLOT_W - 2) || (dy < 2) || (dy >= SLOT_H - 2);
    if (q_Input && int'(guess_num) < ROWS && r == int'(guess_num) && border && cursor_phase())
      return 12'hFFF;
    shown = !(m_rev && r == m_rev_row && m_ticks < RF * (c + 1));
    if (!shown) return 12'h000;
    case (fb)
      1: return 12'h444;
      2: return 12'hAA0;
      3: return 12'h0A0;
      default: return 12'h000;
    endcase
  endfunction

  always @(posedge clk) begin
    bit tick;
    tick = (hCount == 10'd0) && (vCount == 10'd0);
    if (reset) begin
      m_valid = 1; m_rgb = 12'h000; p_b = 0; p_x = 0; p_y = 0;
      m_rev = 0; m_ticks = 0; m_rev_row = 0; m_frames = 0;
    end else begin
      m_rgb = model_rgb(p_x, p_y, p_b);
      if (!m_rev) begin
        if (reveal_start && int'(guess_num) < ROWS) begin
          m_rev = 1; m_rev_row = int'(guess_num); m_ticks = 0;
        end
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == RF * COLS) m_rev = 0;
      end
      if (tick) m_frames = (m_frames + 1) % 32;
      p_x = int'(hCount); p_y = int'(vCount); p_b = bright;
    end
    #1;
    if (m_valid) begin
      total++;
      if ({vgaR, vgaG, vgaB} !== m_rgb) begin
        bad++;
        $display("FAIL model_rgb t=%0t got=%h want=%h", $time, {vgaR, vgaG, vgaB}, m_rgb);
      end
      total++;
      if (reveal_busy !== m_rev) begin
        bad++;
        $display("FAIL model_busy t=%0t got=%b want=%b", $time, reveal_busy, m_rev);
      end
    end
  end

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic probe(input string name, input int x, input int y, input bit b,
                       input logic [11:0] want);
    @(negedge clk);
    hCount = 10'(x); vCount = 10'(y); bright = b;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk(name, {vgaR, vgaG, vgaB}, want);
    $display("probe %s (%0d,%0d) rgb=%h", name, x, y, {vgaR, vgaG, vgaB});
  endtask

  task automatic drive_pix(input int x, input int y);
    @(negedge clk);
    hCount = 10'(x); vCount = 10'(y); bright = 1'b1;
  endtask

  task automatic frame_tick();
    @(negedge clk);
    hCount = 10'd0; vCount = 10'd0; bright = 1'b0;
    @(negedge clk);
    hCount = 10'd700; vCount = 10'd5;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    reveal_start = 1'b1;
    @(negedge clk);
    reveal_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_sym(input int r, input int c, input int v);
    matrix_flat[(r*COLS+c)*SYM_W +: SYM_W] = SYM_W'(v);
  endtask

  task automatic set_fb(input int r, input int c, input int v);
    feedback_flat[(r*COLS+c)*2 +: 2] = 2'(v);
  endtask

  int          vx [13] = '{184, 248, 312, 376, 440, 184, 248, 312, 200, 201, 208, 159, 290};
  int          vy [13] = '{74, 74, 74, 74, 74, 138, 138, 138, 74, 74, 74, 74, 116};
  logic [11:0] vrgb [13] = '{12'hF00, 12'h0F0, 12'h0FF, 12'h00F, 12'hFF0, 12'hF0F, 12'h888,
                             12'h888, 12'hF00, 12'h444, 12'h000, 12'h000, 12'h0A0};

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bright = 1'b0; hCount = 10'd700; vCount = 10'd5;
    matrix_flat = '0; feedback_flat = '0; guess_num = 3'd0; q_Input = 1'b0; reveal_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_rgb", {vgaR, vgaG, vgaB}, 12'h000);
    chk("reset_busy", {11'd0, reveal_busy}, 12'h000);
    reset = 1'b0;

    // Symbol colours, peg radius boundary, margin and outside-grid pixels.
    set_sym(0, 0, 4); set_sym(0, 1, 2); set_sym(0, 2, 3); set_sym(0, 3, 1); set_sym(0, 4, 5);
    set_sym(1, 0, 6); set_sym(1, 1, 7); set_sym(1, 2, 0);
    set_fb(0, 0, 1); set_fb(1, 2, 3);
    for (int i = 0; i < 13; i++) probe($sformatf("vec%0d", i), vx[i], vy[i], 1'b1, vrgb[i]);
    probe("bright_low", 184, 74, 1'b0, 12'h000);
    set_fb(1, 2, 0);
    probe("fb_none", 290, 116, 1'b1, 12'h000);

    // Cursor on row 2.
    do_reset();
    guess_num = 3'd2; q_Input = 1'b1;
`ifdef WORDLE_CURSOR_BLINK_EN
    probe("cursor_blink_off", 160, 178, 1'b1, 12'h000);
    repeat (16) frame_tick();
    probe("cursor_blink_on", 160, 178, 1'b1, 12'hFFF);
`else
    probe("cursor", 160, 178, 1'b1, 12'hFFF);
`endif
    set_fb(2, 0, 2);
    probe("cursor_over_fb", 160, 178, 1'b1, 12'hFFF);
    probe("fb_inner", 170, 188, 1'b1, 12'hAA0);
    q_Input = 1'b0;
    probe("no_input", 160, 178, 1'b1, 12'hAA0);
    q_Input = 1'b1; guess_num = 3'd6;
    probe("gn_out_of_range", 160, 178, 1'b1, 12'hAA0);
    pulse_start();
    chk("start_ignored_gn", {11'd0, reveal_busy}, 12'h000);

    // Reveal of row 2, started on a tick cycle.
    q_Input = 1'b0; guess_num = 3'd2;
    for (int c = 0; c < COLS; c++) set_fb(2, c, 3);
    @(negedge clk);
    hCount = 10'd0; vCount = 10'd0; bright = 1'b0; reveal_start = 1'b1;
    @(negedge clk);
    reveal_start = 1'b0; hCount = 10'd700; vCount = 10'd5;
    chk("busy_after_start", {11'd0, reveal_busy}, 12'h001);
    probe("hidden_c0", 170, 188, 1'b1, 12'h000);
    for (int t = 1; t <= RF * COLS; t++) begin
      frame_tick();
      if (t == RF * COLS - 1) chk("busy_last_tick", {11'd0, reveal_busy}, 12'h001);
      if (t == RF * COLS) chk("busy_done", {11'd0, reveal_busy}, 12'h000);
      if (t == RF) begin
        probe("tick15_c0", 170, 188, 1'b1, 12'h0A0);
        probe("tick15_c1", 234, 188, 1'b1, 12'h000);
      end
      if (t == 2 * RF) begin
        pulse_start();
        probe("no_restart_c1", 234, 188, 1'b1, 12'h0A0);
      end
      for (int c = 0; c < COLS; c++) drive_pix(170 + PX * c, 188);
    end
    probe("all_shown_c4", 426, 188, 1'b1, 12'h0A0);

    // Reset in the middle of a reveal.
    pulse_start();
    repeat (20) frame_tick();
    probe("mid_c0", 170, 188, 1'b1, 12'h0A0);
    probe("mid_c2", 298, 188, 1'b1, 12'h000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("busy_reset", {11'd0, reveal_busy}, 12'h000);
    reset = 1'b0;
    frame_tick();
    probe("after_reset_c4", 426, 188, 1'b1, 12'h0A0);
    probe("after_reset_c2", 298, 188, 1'b1, 12'h0A0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
